// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM states, output bundle and register constants for hazard_ctrl
package Hazard_Ctrl_PKG;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX
module load_use_detect
    import Hazard_Ctrl_PKG::*;
(
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    input  logic       idex_memread,
    input  logic [4:0] idex_rd,
    output logic       hazard
);

    assign hazard = idex_memread && (idex_rd != X0) &&
                    ((ifid_use_rs1 && (idex_rd == ifid_rs1)) ||
                     (ifid_use_rs2 && (idex_rd == ifid_rs2)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage pipeline buffers (load-use, redirect, memory wait with timeout)
// Optional performance counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import Hazard_Ctrl_PKG::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ifid_rs1,
    input  logic [4:0]        ifid_rs2,
    input  logic              ifid_use_rs1,
    input  logic              ifid_use_rs2,
    input  logic              idex_memread,
    input  logic [4:0]        idex_rd,
    input  logic              ex_redirect,
    input  logic              exmem_memread,
    input  logic              exmem_memwrite,
    input  logic              dmem_ready,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic              memwb_bubble,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_count,
`endif
    output logic              mem_err
);

    localparam int WCW = $clog2(MAX_WAIT) + 1;

    localparam hz_ctrl_t MEM_HOLD = '{pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                      idex_stall: 1'b1, idex_flush: 1'b0, exmem_stall: 1'b1,
                                      memwb_bubble: 1'b1};
    localparam hz_ctrl_t REDIRECT = '{pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1,
                                      idex_stall: 1'b0, idex_flush: 1'b1, exmem_stall: 1'b0,
                                      memwb_bubble: 1'b0};
    localparam hz_ctrl_t LOAD_USE = '{pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0,
                                      idex_stall: 1'b0, idex_flush: 1'b1, exmem_stall: 1'b0,
                                      memwb_bubble: 1'b0};

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;
    logic           lu_hazard;
    logic           mem_req;
    hz_ctrl_t       ctrl;
    hz_ctrl_t       ctrl_out;

    load_use_detect u_lud (
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .hazard       (lu_hazard)
    );

    assign mem_req = exmem_memread | exmem_memwrite;

    // Next state and Mealy controls; redirect outranks load-use, memory hold outranks both
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = '0;
        case (state_q)
            RUN: begin
                if (mem_req && !dmem_ready) begin
                    ctrl       = MEM_HOLD;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    ctrl = ex_redirect ? REDIRECT : (lu_hazard ? LOAD_USE : '0);
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    ctrl       = MEM_HOLD;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    state_d    = (wait_cnt_q == WCW'(MAX_WAIT)) ? ERR : MEM_WAIT;
                end else begin
                    ctrl       = ex_redirect ? REDIRECT : (lu_hazard ? LOAD_USE : '0);
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                ctrl = MEM_HOLD;
            end
        endcase
        mem_err_d = (state_d == ERR);
    end

    // Controls are forced inactive for as long as reset is held low
    assign ctrl_out     = reset ? ctrl : '0;
    assign pc_stall     = ctrl_out.pc_stall;
    assign ifid_stall   = ctrl_out.ifid_stall;
    assign ifid_flush   = ctrl_out.ifid_flush;
    assign idex_stall   = ctrl_out.idex_stall;
    assign idex_flush   = ctrl_out.idex_flush;
    assign exmem_stall  = ctrl_out.exmem_stall;
    assign memwb_bubble = ctrl_out.memwb_bubble;
    assign mem_err      = mem_err_q;

    // State, wait counter and sticky error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_count_q, flush_count_d;

    // Counters advance on stall/flush cycles and freeze once the error state is reached
    always_comb begin
        stall_cycles_d = (state_q == ERR) ? stall_cycles_q : stall_cycles_q + PERF_W'(ctrl_out.pc_stall);
        flush_count_d  = (state_q == ERR) ? flush_count_q : flush_count_q + PERF_W'(ctrl_out.ifid_flush);
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Consumer-side controller for the four inter-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage RV32I core.
- Reads hazard-relevant fields held in those buffers.
- Drives the stall (hold) and flush (bubble) controls that gate the buffers' write side.
- Resolves three hazards: load-use, EX-stage control redirect, and multi-cycle data-memory waits. Memory waits are bounded by a timeout that raises a sticky error.

Parameters:
- MAX_WAIT, 16: maximum consecutive not-ready cycles allowed in MEM_WAIT before entering ERR; legal range 2..255.
- PERF_W, 32: width of the performance counters; only used with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_rs1  in  5  rs1 field of the instruction in the IF/ID buffer.
- ifid_rs2  in  5  rs2 field of the instruction in the IF/ID buffer.
- ifid_use_rs1  in  1  IF/ID instruction reads rs1.
- ifid_use_rs2  in  1  IF/ID instruction reads rs2.
- idex_memread  in  1  MemRead bit of the ID/EX buffer.
- idex_rd  in  5  rd of the ID/EX buffer.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr this cycle.
- exmem_memread  in  1  MemRead bit of the EX/MEM buffer.
- exmem_memwrite  in  1  MemWrite bit of the EX/MEM buffer.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF/ID buffer.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_stall  out  1  hold the ID/EX buffer.
- idex_flush  out  1  load all-zero controls into ID/EX.
- exmem_stall  out  1  hold the EX/MEM buffer.
- memwb_bubble  out  1  load RegWrite=0 into MEM/WB.
- mem_err  out  1  sticky memory-timeout error.

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Wait counter wait_cnt is $clog2(MAX_WAIT)+1 bits.
- Reset (reset=0, asynchronous): state=RUN, wait_cnt=0, mem_err=0. All stall, flush and bubble outputs are forced to 0 while reset is low.
- Outputs are Mealy: combinational from the current state and inputs, in the same cycle. Only state, wait_cnt and mem_err are registered.
- mem_req = exmem_memread | exmem_memwrite.
- Condition memstall, active in RUN when mem_req & !dmem_ready:
  - assert pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble;
  - next state = MEM_WAIT, wait_cnt <= 1.
- MEM_WAIT:
  - While !dmem_ready: same five outputs asserted; wait_cnt increments.
  - If wait_cnt == MAX_WAIT and !dmem_ready: go to ERR.
  - When dmem_ready=1: no mem stall outputs that cycle, so the pipeline advances; go to RUN, wait_cnt <= 0.
- ERR: pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble are held at 1. mem_err=1. Only reset exits ERR.
- ex_redirect while memstall is active or in MEM_WAIT/ERR: ignored. EX is frozen, so the redirect is re-presented on the release cycle.
- Redirect, in RUN without memstall and ex_redirect=1:
  - ifid_flush=1, idex_flush=1, no stalls.
  - Redirect has priority over load-use, since the ID instruction is squashed.
- Load-use, in RUN without memstall or redirect, when idex_memread and idex_rd!=0 and ((ifid_use_rs1 and idex_rd==ifid_rs1) or (ifid_use_rs2 and idex_rd==ifid_rs2)):
  - pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle.
  - Next cycle the load is in MEM and the hazard self-clears.
- A load-use condition coinciding with the release cycle (dmem_ready=1) is evaluated normally in that cycle.
- rd==x0 never causes a load-use stall.
- Stall and flush are never both asserted on the same buffer.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cycles [PERF_W]: counts cycles with pc_stall=1.
  - flush_count [PERF_W]: counts cycles with ifid_flush=1.
- Both counters are reset to 0, wrap modulo 2^PERF_W, and are frozen in ERR.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package Hazard_Ctrl_PKG contains:
  - the state enum typedef hz_state_e (RUN, MEM_WAIT, ERR);
  - a packed struct hz_ctrl_t bundling the seven stall/flush/bubble outputs;
  - localparam X0 = 5'd0.
- One combinational sub-module, load_use_detect, implements the load-use compare (ifid fields plus idex_memread/idex_rd to a 1-bit hazard flag). The FSM and the counters stay in hazard_ctrl.

Test Plan:
- idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0. The same stimulus with idex_rd=0 -> no stall.
- ex_redirect=1 and the load-use condition in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0.
- exmem_memread=1 with dmem_ready low for 3 cycles, then high -> four stall outputs plus memwb_bubble high for 3 cycles, all low on the ready cycle, state back to RUN.
- MAX_WAIT=4 with dmem_ready held low -> stalls for 5 cycles, ERR entered, mem_err=1 and stalls persist. Reset low -> everything 0 asynchronously.
- ex_redirect=1 held during a 2-cycle MEM_WAIT -> no flush while waiting; ifid_flush=idex_flush=1 on the dmem_ready cycle.
- With HAZARD_CTRL_PERF_EN: the above sequence -> stall_cycles equals the observed pc_stall cycle count and flush_count=2; with PERF_W=4, the counter wraps 15->0.
